// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Definitions shared by the 3-port RAM, its write controller and the
// read-side controllers.
//   wr_state_e : write-controller FSM states (CLEAR = zero-fill, RUN = stream)
//   ram_depth  : number of RAM entries for a given address width
// ---------------------------------------------------------------------------
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wr_state_e;

  // The RAM is always a full power of two, so DEPTH-1 is the all-ones
  // address and counters wrap naturally.
  function automatic int unsigned ram_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_addr_counter.sv
// ---------------------------------------------------------------------------
// ram_addr_counter
// Modulo-DEPTH address counter. Used for the zero-fill address and for the
// stream write pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over inc)
//   inc        : advance by one, DEPTH-1 wraps to 0
//   count      : current address
// ---------------------------------------------------------------------------
module ram_addr_counter
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] count
);

  localparam int unsigned DEPTH = ram_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order-
  // dependent simulation and a mismatch against the synthesized netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == LAST_ADDR) ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/ram_write_ctrl.sv
// ---------------------------------------------------------------------------
// ram_write_ctrl
// Write-side controller for the 3-port RAM (one synchronous write port, two
// asynchronous read ports). Zero-fills the RAM after reset or clr, then
// writes a valid/ready stream to sequential, wrapping addresses.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous request to re-zero the RAM and restart
//   s_valid/s_data/s_last/s_ready : upstream stream (s_ready from state/clr)
//   we/w_addr/w_data : registered RAM write port, 1 cycle after accept
//   clearing     : zero-fill in progress
//   wr_ptr       : next address the stream will write
//   fill_count   : beats written in the current frame, saturating at DEPTH
//   frame_len    : length of the last completed frame, saturating at DEPTH
//   frame_done   : one-cycle pulse aligned with the last beat's write
// ---------------------------------------------------------------------------
module ram_write_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  clearing,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic [ADDR_WIDTH:0]   frame_len,
  output logic                  frame_done
);

  localparam int unsigned DEPTH = ram_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  wr_state_e               state;
  wr_state_e               state_nxt;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    clr_cnt_inc;
  logic                    ptr_clr;
  logic                    ptr_inc;
  logic [ADDR_WIDTH:0]     fill_inc;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would infer a latch instead of combinational logic.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    clearing  = 1'b0;
    case (state)
      CLEAR: begin
        clearing = 1'b1;
        // The last zero-fill write is issued on the same edge we leave.
        if (clr_cnt == LAST_ADDR) state_nxt = RUN;
      end
      RUN: begin
        // Ready never looks at s_valid, so upstream may wait on it.
        s_ready = !clr;
      end
      default: state_nxt = CLEAR;
    endcase
    if (clr) state_nxt = CLEAR;
  end

  assign accept = s_valid && s_ready;

  // -------------------------------------------------------------------------
  // Address counters
  // -------------------------------------------------------------------------
  // Zero-fill address: counts only while filling, wraps back to 0 on the
  // final write so a later clr starts from a clean counter anyway.
  assign clr_cnt_inc = (state == CLEAR) && !clr;

  ram_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (clr_cnt_inc),
    .count (clr_cnt)
  );

  // Stream pointer: a completed frame restarts at address 0, an abandoned
  // one (clr) does too.
  assign ptr_clr = clr || (accept && s_last);
  assign ptr_inc = accept && !s_last;

  ram_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ptr_clr),
    .inc   (ptr_inc),
    .count (wr_ptr)
  );

  // -------------------------------------------------------------------------
  // Registered write port and frame bookkeeping
  // -------------------------------------------------------------------------
  assign fill_inc = (fill_count == DEPTH_CNT) ? DEPTH_CNT : fill_count + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we         <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      fill_count <= '0;
      frame_len  <= '0;
      frame_done <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= accept && s_last;

      // The edge that samples clr issues no write; the restarted zero-fill
      // begins at address 0 on the following edge.
      if ((state == CLEAR) && !clr) begin
        we     <= 1'b1;
        w_addr <= clr_cnt;
        w_data <= '0;
      end else if (accept) begin
        we     <= 1'b1;
        w_addr <= wr_ptr;
        w_data <= s_data;
      end

      // frame_len deliberately survives clr: an abandoned frame never
      // completes, so the last completed length stays valid.
      if (clr) begin
        fill_count <= '0;
      end else if (accept) begin
        if (s_last) begin
          fill_count <= '0;
          frame_len  <= fill_inc;
        end else begin
          fill_count <= fill_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_write_ctrl
// Directed bench for ram_write_ctrl (ADDR_WIDTH=3, DATA_WIDTH=8). Expected
// RAM writes are queued as stimulus is driven and popped by a write-port
// monitor; a behavioural copy of the RAM is built from the DUT's writes and
// compared against the bench's own expected memory image.
// ---------------------------------------------------------------------------
module tb_ram_write_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          clearing;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   fill_count;
  logic [AW:0]   frame_len;
  logic          frame_done;

  ram_write_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .we         (we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .clearing   (clearing),
    .wr_ptr     (wr_ptr),
    .fill_count (fill_count),
    .frame_len  (frame_len),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          fd;
  } wr_t;

  wr_t           sb_q[$];
  logic [DW-1:0] ram[DEPTH];
  logic [DW-1:0] exp_mem[DEPTH];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            ptr_m;
  int            fill_m;
  int            flen_m;
  int            last_wa;
  int            last_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (we === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_we", 32'(we), 0);
        end else begin
          wr_t e;
          e = sb_q.pop_front();
          check("w_addr", 32'(w_addr), 32'(e.addr));
          check("w_data", 32'(w_data), 32'(e.data));
          check("frame_done_with_we", 32'(frame_done), 32'(e.fd));
        end
        ram[w_addr] = w_data;
      end else begin
        check("frame_done_without_we", 32'(frame_done), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_zero_fill();
    for (int i = 0; i < DEPTH; i++) begin
      sb_q.push_back('{addr: AW'(i), data: '0, fd: 1'b0});
      exp_mem[i] = '0;
    end
    last_wa = DEPTH - 1;
    last_wd = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, 32'(we), 0);
    check({tag, "_w_addr"}, 32'(w_addr), 0);
    check({tag, "_w_data"}, 32'(w_data), 0);
    check({tag, "_clearing"}, 32'(clearing), 1);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_wr_ptr"}, 32'(wr_ptr), 0);
    check({tag, "_fill_count"}, 32'(fill_count), 0);
    check({tag, "_frame_len"}, 32'(frame_len), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < DEPTH; i++) check($sformatf("%s_ram%0d", tag, i), 32'(ram[i]), 32'(exp_mem[i]));
  endtask

  // Runs DEPTH zero-fill cycles from just after the state enters CLEAR.
  task automatic run_zero_fill(input string tag);
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      check({tag, "_clearing"}, 32'(clearing), (k < DEPTH) ? 1 : 0);
      if (k == DEPTH) s_valid = 1'b0;
    end
  endtask

  // One accepted beat; called and returning at posedge+1.
  task automatic beat(input logic [DW-1:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    #1;
    check("s_ready_run", 32'(s_ready), 1);
    sb_q.push_back('{addr: AW'(ptr_m), data: d, fd: last});
    exp_mem[ptr_m] = d;
    last_wa = ptr_m;
    last_wd = int'(d);
    if (last) begin
      flen_m = (fill_m + 1 > DEPTH) ? DEPTH : fill_m + 1;
      ptr_m  = 0;
      fill_m = 0;
    end else begin
      ptr_m  = (ptr_m + 1) % DEPTH;
      fill_m = (fill_m + 1 > DEPTH) ? DEPTH : fill_m + 1;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("wr_ptr", 32'(wr_ptr), 32'(ptr_m));
    check("fill_count", 32'(fill_count), 32'(fill_m));
    check("frame_len", 32'(frame_len), 32'(flen_m));
  endtask

  // One cycle without s_valid; junk data must not be written.
  task automatic idle();
    s_valid = 1'b0;
    s_data  = DW'($urandom);
    s_last  = 1'($urandom);
    tick();
    check("idle_we", 32'(we), 0);
    check("idle_w_addr_hold", 32'(w_addr), 32'(last_wa));
    check("idle_w_data_hold", 32'(w_data), 32'(last_wd));
    check("idle_wr_ptr", 32'(wr_ptr), 32'(ptr_m));
    check("idle_fill_count", 32'(fill_count), 32'(fill_m));
    s_last = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    ptr_m   = 0;
    fill_m  = 0;
    flen_m  = 0;

    // Reset state and first zero-fill.
    #2;
    check_reset_vals("por");
    push_zero_fill();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    check("fill_start_clearing", 32'(clearing), 1);
    run_zero_fill("por_fill");
    check("run_s_ready", 32'(s_ready), 1);
    idle();
    check("fill_drain", sb_q.size(), 0);
    check_ram("fill");

    // Three-beat frame with s_valid held high.
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b1);
    idle();
    check("f3_len", 32'(frame_len), 3);
    check("f3_drain", sb_q.size(), 0);
    check_ram("f3");

    // Ten-beat frame wraps over the oldest entries.
    for (int i = 0; i < 10; i++) beat(8'hA0 + DW'(i), (i == 9));
    idle();
    check("f10_len", 32'(frame_len), 8);
    check("f10_ram0", 32'(ram[0]), 32'h0A8);
    check("f10_ram1", 32'(ram[1]), 32'h0A9);
    check("f10_ram2", 32'(ram[2]), 32'h0A2);
    check("f10_drain", sb_q.size(), 0);
    check_ram("f10");

    // Valid with gaps.
    beat(8'h61, 1'b0);
    idle();
    beat(8'h62, 1'b0);
    idle();
    idle();
    beat(8'h63, 1'b1);
    idle();
    check("gap_len", 32'(frame_len), 3);
    check("gap_drain", sb_q.size(), 0);
    check_ram("gap");

    // clr after four beats with s_valid still high.
    for (int i = 0; i < 4; i++) beat(8'hC0 + DW'(i), 1'b0);
    clr     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    s_last  = 1'b1;
    #1;
    check("clr_s_ready", 32'(s_ready), 0);
    push_zero_fill();
    ptr_m  = 0;
    fill_m = 0;
    tick();
    clr = 1'b0;
    check("clr_we", 32'(we), 0);
    check("clr_clearing", 32'(clearing), 1);
    check("clr_wr_ptr", 32'(wr_ptr), 0);
    check("clr_fill_count", 32'(fill_count), 0);
    check("clr_frame_done", 32'(frame_done), 0);
    check("clr_frame_len", 32'(frame_len), 32'(flen_m));
    run_zero_fill("clr_fill");
    idle();
    check("clr_frame_len_after", 32'(frame_len), 32'(flen_m));
    check("clr_drain", sb_q.size(), 0);
    check_ram("clr");

    // Reset mid-frame.
    beat(8'h51, 1'b0);
    beat(8'h52, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    ptr_m  = 0;
    fill_m = 0;
    flen_m = 0;
    check_reset_vals("rst_frame");
    push_zero_fill();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    tick();

    // Reset mid-zero-fill.
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check_reset_vals("rst_fill");
    push_zero_fill();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_zero_fill("rst_refill");
    idle();
    check("rst_drain", sb_q.size(), 0);
    check_ram("rst");

    // Recovery: single-beat frame.
    beat(8'h77, 1'b1);
    idle();
    check("f1_len", 32'(frame_len), 1);
    check("f1_drain", sb_q.size(), 0);
    check_ram("f1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
